spinv_march_ctrl: RTL and testbench

SPINV_MARCH_CTRL -- requirements
Module: spinv_march_ctrl

---
 rtl/spinv_march_ctrl.sv | 161 ++++++++++++++++
 tb/tb_spinv_march_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spinv_march_ctrl.sv
// Space-invaders formation march controller: stepping, row drops, win/lose, score.
// Optional SPINV_SPEEDUP_EN shortens the step interval as aliens die.
module spinv_march_ctrl #(
    parameter int STEP_FRAMES = 30,
    parameter int STEP_X      = 10,
    parameter int STEP_Y      = 20,
    parameter int X_MAX       = 100,
    parameter int Y_LIMIT     = 240
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic [14:0] alive,
    input  logic        hit,
    output logic [9:0]  offsetX,
    output logic [9:0]  offsetY,
    output logic        dir,
    output logic        step_pulse,
    output logic [1:0]  state,
    output logic [9:0]  score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARCH = 2'd1,
        S_WIN   = 2'd2,
        S_LOSE  = 2'd3
    } st_t;

    localparam logic [9:0] SX  = 10'(STEP_X);
    localparam logic [9:0] SY  = 10'(STEP_Y);
    localparam logic [9:0] XM  = 10'(X_MAX);
    localparam logic [9:0] YL  = 10'(Y_LIMIT);
    localparam logic [9:0] SF  = 10'(STEP_FRAMES);

    st_t        state_q, state_d;
    logic [9:0] offx_q, offx_d;
    logic [9:0] offy_q, offy_d;
    logic       dir_q, dir_d;
    logic       pulse_q, pulse_d;
    logic [9:0] score_q, score_d;
    logic [9:0] cnt_q, cnt_d;

    logic [9:0]  interval;
    logic [10:0] x_sum, y_sum, s_sum;
    logic        step_go;

`ifdef SPINV_SPEEDUP_EN
    logic [3:0] ones;
    logic [3:0] dead;
    logic [9:0] dead2;

    always_comb begin
        ones = '0;
        for (int i = 0; i < 15; i++) begin
            ones = ones + 4'(alive[i]);
        end
        dead  = 4'd15 - ones;
        dead2 = {5'd0, dead, 1'b0};
        interval = (SF >= 10'd4 + dead2) ? SF - dead2 : 10'd4;
    end
`else
    assign interval = SF;
`endif

    // Widened by one bit so the limit tests below cannot wrap.
    assign x_sum = {1'b0, offx_q} + {1'b0, SX};
    assign y_sum = {1'b0, offy_q} + {1'b0, SY};
    assign s_sum = {1'b0, score_q} + 11'd10;

    always_comb begin
        state_d = state_q;
        offx_d  = offx_q;
        offy_d  = offy_q;
        dir_d   = dir_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        step_go = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                offx_d = '0;
                offy_d = '0;
                dir_d  = 1'b1;
                cnt_d  = '0;
                if (start) begin
                    state_d = S_MARCH;
                    score_d = '0;
                end
            end
            S_MARCH: begin
                if (hit) begin
                    score_d = (s_sum > 11'd1000) ? 10'd1000 : s_sum[9:0];
                end
                if (alive == '0) begin
                    state_d = S_WIN;
                end else if (offy_q >= YL) begin
                    state_d = S_LOSE;
                end else if (frame_tick) begin
                    if (cnt_q >= interval - 10'd1) begin
                        cnt_d   = '0;
                        step_go = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
                if (step_go) begin
                    pulse_d = 1'b1;
                    if ((dir_q && x_sum > {1'b0, XM}) ||
                        (!dir_q && offx_q < SX)) begin
                        offy_d = y_sum[10] ? 10'h3FF : y_sum[9:0];
                        dir_d  = ~dir_q;
                    end else if (dir_q) begin
                        offx_d = x_sum[9:0];
                    end else begin
                        offx_d = offx_q - SX;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (start) begin
                    state_d = S_IDLE;
                    offx_d  = '0;
                    offy_d  = '0;
                    dir_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            offx_q  <= '0;
            offy_q  <= '0;
            dir_q   <= 1'b1;
            pulse_q <= 1'b0;
            score_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            offx_q  <= offx_d;
            offy_q  <= offy_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
        end
    end

    assign offsetX    = offx_q;
    assign offsetY    = offy_q;
    assign dir        = dir_q;
    assign step_pulse = pulse_q;
    assign state      = state_q;
    assign score      = score_q;

endmodule

// File: tb/tb_spinv_march_ctrl.sv
// Scoreboard bench for spinv_march_ctrl: expected step positions are queued
// by the stimulus and popped by a monitor on every step_pulse.
module tb_spinv_march_ctrl;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        frame_tick = 1'b0;
    logic [14:0] alive = 15'h7FFF;
    logic        hit = 1'b0;
    logic [9:0]  offsetX, offsetY, score;
    logic        dir, step_pulse;
    logic [1:0]  state;

    spinv_march_ctrl dut (
        .Clk(Clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .alive(alive), .hit(hit), .offsetX(offsetX), .offsetY(offsetY),
        .dir(dir), .step_pulse(step_pulse), .state(state), .score(score)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       d;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   k = 0;
    int   tc = 0;
    int   ivl = 30;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0d req=%0d", nm, act, req);
        end
    endtask

    // Closed form: 11 steps per row (10 moves plus one drop).
    function automatic exp_t pos(input int n);
        exp_t e;
        int   drops = n / 11;
        int   r = n % 11;
        e.y = 10'(20 * drops);
        if (drops % 2 == 0) begin
            e.d = 1'b1;
            e.x = 10'(10 * r);
        end else begin
            e.d = 1'b0;
            e.x = 10'(100 - 10 * r);
        end
        return e;
    endfunction

    task automatic ticks(input int n, input bit hit_last);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            frame_tick = 1'b1;
            hit = hit_last && (i == n - 1);
            tc++;
            if (tc == ivl) begin
                tc = 0;
                k++;
                sb.push_back(pos(k));
            end
        end
        @(negedge Clk);
        frame_tick = 1'b0;
        hit = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge Clk);
        chk(nm, sb.size(), 0);
    endtask

    task automatic pulse_hit();
        @(negedge Clk);
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic new_game();
        pulse_start();
        k = 0;
        tc = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (step_pulse) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL step_unexpected x=%0d y=%0d req=no step",
                             offsetX, offsetY);
                end else begin
                    e = sb.pop_front();
                    if (offsetX !== e.x || offsetY !== e.y ||
                        dir !== e.d || state !== 2'd1) begin
                        bad++;
                        $display("FAIL step act x=%0d y=%0d d=%0d st=%0d req x=%0d y=%0d d=%0d st=1",
                                 offsetX, offsetY, dir, state, e.x, e.y, e.d);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_state", state, 0);
        chk("rst_x", offsetX, 0);
        chk("rst_y", offsetY, 0);
        chk("rst_dir", dir, 1);
        chk("rst_pulse", step_pulse, 0);
        chk("rst_score", score, 0);
        reset = 1'b0;
        repeat (2) @(negedge Clk);
        chk("idle_hold", state, 0);

        new_game();
        chk("march_state", state, 1);
        chk("score_clr", score, 0);
        ticks(30, 1'b0);
        drain("step1_drain");
        chk("step1_state", state, 1);

        pulse_hit();
        chk("score_hit1", score, 10);
        ticks(30, 1'b1);
        drain("step2_drain");
        chk("score_hit_step", score, 20);
        for (int i = 0; i < 98; i++) pulse_hit();
        chk("score_1000", score, 1000);
        pulse_hit();
        chk("score_sat", score, 1000);

        ticks(300, 1'b0);
        drain("row_drop_drain");
        chk("after_drop_x", offsetX, 90);
        chk("after_drop_dir", dir, 0);

        ticks(3600, 1'b0);
        drain("land_drain");
        @(negedge Clk);
        chk("lose_state", state, 3);
        chk("lose_y", offsetY, 240);
        @(negedge Clk);
        frame_tick = 1'b1;
        hit = 1'b1;
        repeat (40) @(negedge Clk);
        frame_tick = 1'b0;
        hit = 1'b0;
        chk("lose_frozen_y", offsetY, 240);
        chk("lose_frozen_x", offsetX, 0);
        chk("lose_score", score, 1000);

        pulse_start();
        chk("lose_to_idle", state, 0);
        chk("idle_x", offsetX, 0);
        chk("idle_y", offsetY, 0);
        chk("idle_dir", dir, 1);
        pulse_hit();
        chk("idle_hit_ign", score, 1000);

        new_game();
        chk("win_score_clr", score, 0);
        ticks(29, 1'b0);
        @(negedge Clk);
        frame_tick = 1'b1;
        alive = '0;
        @(negedge Clk);
        frame_tick = 1'b0;
        chk("win_state", state, 2);
        chk("win_x", offsetX, 0);
        repeat (3) @(negedge Clk);
        chk("win_hold", state, 2);

        alive = 15'h7FFF;
        pulse_start();
        chk("win_to_idle", state, 0);
        new_game();
        pulse_hit();
        ticks(15, 1'b0);
        @(negedge Clk);
        reset = 1'b1;
        frame_tick = 1'b1;
        hit = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        frame_tick = 1'b0;
        hit = 1'b0;
        start = 1'b0;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_pulse", step_pulse, 0);
        new_game();
        ticks(30, 1'b0);
        drain("post_rst_drain");

`ifdef SPINV_SPEEDUP_EN
        @(negedge Clk);
        alive = 15'h7FE0;
        ivl = 20;
        ticks(40, 1'b0);
        drain("speed20_drain");
        @(negedge Clk);
        alive = 15'h4000;
        ivl = 4;
        ticks(8, 1'b0);
        drain("speed4_drain");
`else
        @(negedge Clk);
        alive = 15'h4000;
        ticks(30, 1'b0);
        drain("fixed_ivl_drain");
`endif

        repeat (5) @(negedge Clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
